// File: rtl/pmc_pkg.sv
// pmc_pkg: shared state encoding and pattern-length clamp for pattern_match_ctrl
package pmc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_e;
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len == 32'd0) ? 32'd1 : (len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/bit_window.sv
// bit_window: serial shift window with fill count and len-masked pattern compare
module bit_window #(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               din,
  input  logic               overlap,
  input  logic [LW-1:0]      len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match
);
  logic [MAX_LEN-1:0] win_q, win_d, win_nx, mask;
  logic [LW-1:0]      fill_q, fill_d, fill_nx;
  // match looks at the post-shift window so the flag lines up with the sampling edge
  always_comb begin
    win_nx  = {win_q[MAX_LEN-2:0], din};
    fill_nx = (fill_q >= len) ? len : fill_q + 1'b1;
    mask    = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len);
    match   = shift && (fill_nx >= len) && (((win_nx ^ pattern) & mask) == '0);
    win_d   = clr ? '0 : shift ? win_nx : win_q;
    fill_d  = clr ? '0 : !shift ? fill_q : (match && !overlap) ? '0 : fill_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl: armed serial pattern detector with match target and idle timeout
module pattern_match_ctrl
  import pmc_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic [CNT_W-1:0]               cfg_target,
  input  logic [TMO_W-1:0]               cfg_timeout,
  input  logic                           arm,
  input  logic                           clear,
  input  logic                           dataIn,
  input  logic                           dataValid,
  output logic                           detected,
  output logic [CNT_W-1:0]               match_count,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_e             st_q, st_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0]   tmo_q, tcnt_q, tcnt_d, tcnt_inc;
  logic               det_q, det_d, tf_q, tf_d;
  logic               win_clr, shift, hit;
  // arm is ignored while a run is in progress, so data keeps flowing
  assign shift   = (st_q == ARMED) && !clear && dataValid;
  assign win_clr = !clear && arm && (st_q != ARMED);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign tcnt_inc = tcnt_q + 1'b1;
  bit_window #(.MAX_LEN(MAX_LEN), .LW(LW)) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (win_clr),
    .shift   (shift),
    .din     (dataIn),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .match   (hit)
  );
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    tcnt_d = tcnt_q;
    det_d  = 1'b0;
    tf_d   = tf_q;
    if (clear) begin
      st_d = IDLE;
      tf_d = 1'b0;
    end else if (win_clr) begin
      st_d   = ARMED;
      cnt_d  = '0;
      tcnt_d = '0;
      tf_d   = 1'b0;
    end else if (shift) begin
      if (hit) begin
        det_d  = 1'b1;
        cnt_d  = cnt_inc;
        tcnt_d = '0;
        st_d   = (tgt_q != '0 && cnt_inc == tgt_q) ? DONE : ARMED;
      end else begin
        tcnt_d = tcnt_inc;
        st_d   = (tmo_q != '0 && tcnt_inc == tmo_q) ? DONE : ARMED;
        tf_d   = (tmo_q != '0 && tcnt_inc == tmo_q);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      tcnt_q <= '0;
      det_q  <= 1'b0;
      tf_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
      det_q  <= det_d;
      tf_q   <= tf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= LW'(1);
      ovl_q <= 1'b0;
      tgt_q <= '0;
      tmo_q <= '0;
    end else if (cfg_we && st_q == IDLE) begin
      pat_q <= cfg_pattern;
      len_q <= LW'(clamp_len(32'(cfg_len), MAX_LEN));
      ovl_q <= cfg_overlap;
      tgt_q <= cfg_target;
      tmo_q <= cfg_timeout;
    end
  end
  assign detected    = det_q;
  assign match_count = cnt_q;
  assign busy        = (st_q == ARMED);
  assign done        = (st_q == DONE);
  assign timeout     = tf_q;
endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb_pattern_match_ctrl: directed scenarios plus randomized runs against a history-based model
module tb_pattern_match_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic [7:0]  cfg_target = '0;
  logic [11:0] cfg_timeout = '0;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic        dataIn = 1'b0;
  logic        dataValid = 1'b0;
  logic        detected, busy, done, timeout;
  logic [7:0]  match_count;
  int checks = 0;
  int errors = 0;

  pattern_match_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .arm(arm), .clear(clear), .dataIn(dataIn), .dataValid(dataValid),
    .detected(detected), .match_count(match_count), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic [7:0] t, input logic [11:0] tm);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = tm;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drive(input logic d, input logic v);
    dataIn = d; dataValid = v;
    @(negedge clk);
    dataValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_detected got %b want 0", detected); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst_n = 1'b1;
    pulse_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b want 1", busy); end
    drive(1'b0, 1'b1);
    checks++; if (detected !== 1'b1) begin errors++; $display("FAIL default_len1_hit got %b want 1", detected); end
    drive(1'b1, 1'b1);
    checks++; if (detected !== 1'b0) begin errors++; $display("FAIL default_len1_miss got %b want 0", detected); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL default_count got %0d want 1", match_count); end
    pulse_clear();
  endtask

  task automatic run_stream(input string name, input logic o, input logic [6:0] exp_det, input logic [7:0] exp_cnt);
    logic [6:0] bits;
    bits = 7'b1011011;
    configure(8'b1011, 4'd4, o, 8'd0, 12'd0);
    pulse_arm();
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i], 1'b1);
      checks++;
      if (detected !== exp_det[6-i]) begin
        errors++; $display("FAIL %s_det bit%0d got %b want %b", name, i + 1, detected, exp_det[6-i]);
      end
    end
    checks++; if (match_count !== exp_cnt) begin errors++; $display("FAIL %s_count got %0d want %0d", name, match_count, exp_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", name, busy); end
    pulse_clear();
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1, 7'b0001001, 8'd2);
  endtask

  task automatic test_nonoverlap();
    run_stream("nonoverlap", 1'b0, 7'b0001000, 8'd1);
  endtask

  task automatic test_target();
    logic [6:0] bits, exp_det;
    bits = 7'b0101010;
    exp_det = 7'b0101010;
    configure(8'b01, 4'd2, 1'b0, 8'd3, 12'd0);
    pulse_arm();
    for (int i = 0; i < 6; i++) begin
      drive(bits[6-i], 1'b1);
      checks++;
      if (detected !== exp_det[6-i]) begin errors++; $display("FAIL target_det bit%0d got %b want %b", i + 1, detected, exp_det[6-i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL target_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL target_busy got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL target_timeout got %b want 0", timeout); end
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (detected !== 1'b0) begin errors++; $display("FAIL target_ignored_det got %b want 0", detected); end
    checks++; if (match_count !== 8'd3) begin errors++; $display("FAIL target_count got %0d want 3", match_count); end
    pulse_clear();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL target_clear_done got %b want 0", done); end
  endtask

  task automatic test_timeout();
    configure(8'b1011, 4'd4, 1'b0, 8'd0, 12'd5);
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      checks++;
      if (done !== (i == 4)) begin errors++; $display("FAIL timeout_done bit%0d got %b want %b", i + 1, done, (i == 4)); end
      checks++;
      if (timeout !== (i == 4)) begin errors++; $display("FAIL timeout_flag bit%0d got %b want %b", i + 1, timeout, (i == 4)); end
    end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL timeout_count got %0d want 0", match_count); end
    pulse_clear();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout); end
  endtask

  task automatic test_priority();
    configure(8'b01, 4'd2, 1'b1, 8'd0, 12'd0);
    pulse_arm();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    clear = 1'b1; arm = 1'b1;
    @(negedge clk);
    clear = 1'b0; arm = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_arm_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_arm_done got %b want 0", done); end
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL clear_hold_count got %0d want 1", match_count); end
    pulse_arm();
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_we = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (detected !== 1'b1) begin errors++; $display("FAIL armed_cfg_old_hit got %b want 1", detected); end
    drive(1'b1, 1'b1);
    checks++; if (detected !== 1'b0) begin errors++; $display("FAIL armed_cfg_ignored got %b want 0", detected); end
    cfg_we = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL pre_reset_count got %0d want 2", match_count); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL midrun_reset_count got %0d want 0", match_count); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || detected !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_flags got b%b d%b det%b t%b want 0000", busy, done, detected, timeout);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_pat, m_tgt, m_cnt, rp;
    logic [11:0] m_tmo;
    logic [3:0] rl;
    logic m_ovl, m_tf, exp_det, d, v, hit;
    int m_len, m_st, fresh, idle, pos;
    bit q[$];
    for (int r = 0; r < 40; r++) begin
      rp = 8'($urandom);
      rl = 4'($urandom_range(0, 10));
      m_ovl = 1'($urandom);
      m_tgt = 8'($urandom_range(0, 4));
      m_tmo = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1, 12));
      configure(rp, rl, m_ovl, m_tgt, m_tmo);
      m_pat = rp;
      m_len = (rl == 0) ? 1 : (rl > 8) ? 8 : int'(rl);
      pulse_arm();
      m_st = 1; m_cnt = 0; m_tf = 0; fresh = 0; idle = 0; pos = 0;
      q.delete();
      for (int s = 0; s < 50; s++) begin
        v = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 1) == 0) ? m_pat[m_len - 1 - (pos % m_len)] : 1'($urandom);
        if (v) pos++;
        exp_det = 1'b0;
        if (m_st == 1 && v) begin
          q.push_back(d);
          fresh++; idle++;
          hit = (fresh >= m_len);
          if (hit) for (int k = 0; k < m_len; k++) if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          if (hit) begin
            exp_det = 1'b1;
            if (m_cnt != 8'd255) m_cnt++;
            idle = 0;
            if (!m_ovl) fresh = 0;
            if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
          end else if (m_tmo != 0 && idle == int'(m_tmo)) begin
            m_st = 2; m_tf = 1'b1;
          end
        end
        drive(d, v);
        checks++;
        if (detected !== exp_det || match_count !== m_cnt || busy !== (m_st == 1) ||
            done !== (m_st == 2) || timeout !== m_tf) begin
          errors++;
          $display("FAIL random run%0d step%0d got det%b cnt%0d b%b d%b t%b want det%b cnt%0d b%b d%b t%b",
                   r, s, detected, match_count, busy, done, timeout,
                   exp_det, m_cnt, (m_st == 1), (m_st == 2), m_tf);
        end
      end
      pulse_clear();
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_timeout();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
